// File: rtl/reg_transfer_ctrl.sv
// reg_transfer_ctrl: multicycle LOADI/MOV/ADD/SUB sequencer over four 16-bit registers
module reg_transfer_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [15:0] instr,
  input  logic [1:0]  rd_sel,
  output logic [15:0] rd_data,
  output logic [3:0]  reg_we,
  output logic        busy,
  output logic        done,
  output logic        flag_c,
  output logic        flag_z
);
  typedef enum logic [2:0] {IDLE, T1, T2, T3, DN} state_t;
  state_t state, next;
  logic [15:0] r [4];
  logic [15:0] ir, a, g, wdata;
  logic [16:0] sum;
  logic [1:0] op, rx, ry;
  assign op = ir[15:14];
  assign rx = ir[13:12];
  assign ry = ir[11:10];
  assign rd_data = r[rd_sel];
  always_ff @(posedge clk)
    state <= reset ? IDLE : next;
  always_comb begin
    next = state;
    case (state)
      IDLE: next = start ? T1 : IDLE;
      T1:   next = op[1] ? T2 : DN;
      T2:   next = T3;
      T3:   next = DN;
      default: next = IDLE;
    endcase
  end
  // SUB uses the same adder with inverted operand plus one, so bit 16 is no-borrow
  always_comb begin
    busy = state != IDLE;
    done = state == DN;
    reg_we = ((state == T1 && !op[1]) || state == T3) ? 4'b0001 << rx : 4'b0000;
    wdata = state == T3 ? g : (op == 2'b00 ? {6'b0, ir[9:0]} : r[ry]);
    sum = {1'b0, a} + (op[0] ? {1'b0, ~r[ry]} + 17'd1 : {1'b0, r[ry]});
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r <= '{default: '0};
      ir <= '0;
      a <= '0;
      g <= '0;
      flag_c <= 1'b0;
      flag_z <= 1'b0;
    end else begin
      if (state == IDLE && start) ir <= instr;
      if (state == T1) a <= r[rx];
      if (state == T2) begin
        g <= sum[15:0];
        flag_c <= sum[16];
      end
      if (|reg_we) begin
        r[rx] <= wdata;
        flag_z <= wdata == 16'd0;
      end
    end
  end
endmodule

// File: tb/tb_reg_transfer_ctrl.sv
// tb_reg_transfer_ctrl: timeline reference model plus directed literal checks
module tb_reg_transfer_ctrl;
  logic clk = 0, reset = 1, start = 0;
  logic [15:0] instr = '0;
  logic [1:0] rd_sel = '0;
  logic [15:0] rd_data;
  logic [3:0] reg_we;
  logic busy, done, flag_c, flag_z;
  int n_chk = 0, n_fail = 0;
  bit chk_en = 0;

  reg_transfer_ctrl dut (.clk(clk), .reset(reset), .start(start), .instr(instr), .rd_sel(rd_sel),
    .rd_data(rd_data), .reg_we(reg_we), .busy(busy), .done(done), .flag_c(flag_c), .flag_z(flag_z));

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [16:0] act, input logic [16:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  // Model: age counts cycles since the accepting edge; effects land at the end of given ages
  logic [15:0] m_r [4];
  logic [15:0] m_ir;
  logic m_c, m_z;
  int age = 0;

  function automatic int lat(input logic [15:0] i);
    return i[15] ? 5 : 3;
  endfunction

  always @(posedge clk) begin
    int x, y, v;
    if (reset) begin
      m_r = '{default: '0};
      m_c = 0;
      m_z = 0;
      m_ir = '0;
      age = 0;
    end else if (age == 0) begin
      if (start) begin
        m_ir = instr;
        age = 1;
      end
    end else begin
      x = int'(m_r[m_ir[13:12]]);
      y = int'(m_r[m_ir[11:10]]);
      if (!m_ir[15] && age == 1) begin
        v = m_ir[14] ? y : int'(m_ir[9:0]);
        m_r[m_ir[13:12]] = 16'(v);
        m_z = v == 0;
      end
      if (m_ir[15] && age == 2) m_c = m_ir[14] ? (x >= y) : (x + y > 65535);
      if (m_ir[15] && age == 3) begin
        v = m_ir[14] ? x - y : x + y;
        m_r[m_ir[13:12]] = 16'(v);
        m_z = 16'(v) == 16'd0;
      end
      age = (age + 1 == lat(m_ir)) ? 0 : age + 1;
    end
  end

  always @(negedge clk) if (chk_en) begin
    int l, w;
    l = lat(m_ir);
    w = m_ir[15] ? 3 : 1;
    chk("busy", 17'(busy), 17'(age != 0));
    chk("done", 17'(done), 17'(age != 0 && age == l - 1));
    chk("reg_we", 17'(reg_we), 17'((age != 0 && age == w) ? 4'b0001 << m_ir[13:12] : 4'b0000));
    chk("rd_data", 17'(rd_data), 17'(m_r[rd_sel]));
    chk("flag_c", 17'(flag_c), 17'(m_c));
    chk("flag_z", 17'(flag_z), 17'(m_z));
  end

  function automatic logic [15:0] enc(input int op, input int rx, input int ry, input int imm);
    return {2'(op), 2'(rx), 2'(ry), 10'(imm)};
  endfunction

  task automatic issue(input logic [15:0] ins, output int dj);
    int l;
    l = lat(ins);
    start = 1;
    instr = ins;
    dj = -1;
    @(posedge clk); #1;
    start = 0;
    instr = 16'($urandom);
    for (int j = 1; j < l; j++) begin
      if (done && dj < 0) dj = j;
      @(posedge clk); #1;
    end
  endtask

  task automatic peek(input int sel, input logic [15:0] exp, input string n);
    rd_sel = 2'(sel);
    #1;
    chk(n, 17'(rd_data), 17'(exp));
  endtask

  initial begin
    int dj, nd;
    @(posedge clk); #1;
    chk_en = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("rst_busy", 17'(busy), 17'(0));
    for (int i = 0; i < 4; i++) peek(i, 16'h0000, "rst_reg");
    issue(enc(0, 2, 0, 'h155), dj);
    chk("loadi_done_at", 17'(dj), 17'(2));
    peek(2, 16'h0155, "loadi_r2");
    chk("loadi_z", 17'(flag_z), 17'(0));
    peek(0, 16'h0000, "r0_zero");
    peek(1, 16'h0000, "r1_zero");
    peek(3, 16'h0000, "r3_zero");
    issue(enc(0, 0, 0, 'h3FF), dj);
    issue(enc(0, 1, 0, 'h001), dj);
    issue(enc(2, 0, 1, 0), dj);
    chk("add_done_at", 17'(dj), 17'(4));
    peek(0, 16'h0400, "add_r0");
    chk("add_c", 17'(flag_c), 17'(0));
    issue(enc(1, 3, 0, 0), dj);
    peek(3, 16'h0400, "mov_r3");
    repeat (5) issue(enc(2, 0, 0, 0), dj);
    peek(0, 16'h8000, "dbl_r0");
    issue(enc(2, 0, 0, 0), dj);
    peek(0, 16'h0000, "wrap_r0");
    chk("wrap_c", 17'(flag_c), 17'(1));
    chk("wrap_z", 17'(flag_z), 17'(1));
    issue(enc(0, 1, 0, 5), dj);
    issue(enc(3, 1, 1, 0), dj);
    peek(1, 16'h0000, "subself_r1");
    chk("subself_c", 17'(flag_c), 17'(1));
    chk("subself_z", 17'(flag_z), 17'(1));
    issue(enc(0, 0, 0, 2), dj);
    issue(enc(0, 1, 0, 3), dj);
    issue(enc(3, 0, 1, 0), dj);
    peek(0, 16'hFFFF, "sub_neg_r0");
    chk("sub_neg_c", 17'(flag_c), 17'(0));
    chk("sub_neg_z", 17'(flag_z), 17'(0));
    issue(enc(0, 1, 0, 7), dj);
    issue(enc(0, 2, 0, 9), dj);
    start = 1;
    instr = enc(2, 1, 2, 0);
    nd = 0;
    @(posedge clk); #1;
    for (int j = 1; j <= 8; j++) begin
      if (done) nd++;
      if (j <= 3) instr = enc(0, 3, 0, $urandom_range(0, 1023));
      if (j == 4) instr = enc(0, 3, 0, 'h123);
      if (j == 6) start = 0;
      if (j < 8) begin
        @(posedge clk); #1;
      end
    end
    chk("held_done_count", 17'(nd), 17'(2));
    peek(1, 16'h0010, "held_r1");
    peek(3, 16'h0123, "held_r3");
    issue(enc(0, 1, 0, 7), dj);
    start = 1;
    instr = enc(2, 1, 2, 0);
    @(posedge clk); #1;
    start = 0;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    chk("abort_busy", 17'(busy), 17'(0));
    chk("abort_we", 17'(reg_we), 17'(0));
    chk("abort_c", 17'(flag_c), 17'(0));
    for (int i = 0; i < 4; i++) peek(i, 16'h0000, "abort_reg");
    for (int c = 0; c < 400; c++) begin
      start = 1'($urandom_range(0, 3) != 0);
      instr = 16'($urandom);
      rd_sel = 2'($urandom);
      reset = ($urandom_range(0, 79) == 0);
      @(posedge clk); #1;
    end
    reset = 0;
    start = 0;
    repeat (6) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
